// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM-side bus of the sprite ROM arbiter: packed per-port requests and
// addresses, one-hot grants and returns, and the shared ROM address/data pair.
interface sprite_rom_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 17,
  parameter int DW    = 4
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ-1:0]    gnt;
  logic [AW-1:0]       rom_address;
  logic [DW-1:0]       rom_q;
  logic [N_REQ-1:0]    rvalid;
  logic [DW-1:0]       rdata;

  // Requesters and the ROM sit on the master side; the arbiter is the slave.
  modport master (
    output req, addr, rom_q,
    input  gnt, rom_address, rvalid, rdata
  );

  modport slave (
    input  req, addr, rom_q,
    output gnt, rom_address, rvalid, rdata
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM read port: port 0 (pixel draw) has fixed priority,
// secondary ports are round-robin with a starvation guard that can pre-empt port 0.
module sprite_rom_arbiter #(
  parameter int N_REQ      = 4,
  parameter int AW         = 17,
  parameter int DW         = 4,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  sprite_rom_arbiter_if.slave  bus
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SAT      = CW'(STARVE_MAX);
  localparam logic [PW-1:0] RR_FIRST = PW'(1);

  logic [PW-1:0]    r_rr_ptr;
  logic [CW-1:0]    r_wait [1:N_REQ-1];
  logic [N_REQ-1:0] r_pipe [ROM_LAT];
  logic [N_REQ-1:0] r_gnt;
  logic [AW-1:0]    r_rom_address;
  logic [N_REQ-1:0] r_rvalid;
  logic [DW-1:0]    r_rdata;

  logic             w_win_valid;
  logic             w_win_rr;
  logic [PW-1:0]    w_win_idx;
  logic [N_REQ-1:0] w_win_oh;
  logic [AW-1:0]    w_win_addr;

  // Secondary slot visited at a given offset from the pointer, wrapping past N_REQ-1 to 1.
  function automatic logic [PW-1:0] rr_slot(input logic [PW-1:0] ptr, input int off);
    int j;
    j = int'(ptr) + off;
    if (j >= N_REQ) j = j - (N_REQ - 1);
    return PW'(j);
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] k);
    if (int'(k) >= N_REQ - 1) return RR_FIRST;
    return k + RR_FIRST;
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_rr    = 1'b0;
    w_win_idx   = '0;
    // Descending scans let the lowest index / smallest offset win.
    for (int i = N_REQ - 1; i >= 1; i--) begin
      if (bus.req[i] && r_wait[i] == SAT) begin
        w_win_valid = 1'b1;
        w_win_idx   = PW'(i);
      end
    end
    if (!w_win_valid && bus.req[0]) begin
      w_win_valid = 1'b1;
    end
    if (!w_win_valid) begin
      for (int off = N_REQ - 2; off >= 0; off--) begin
        if (bus.req[rr_slot(r_rr_ptr, off)]) begin
          w_win_valid = 1'b1;
          w_win_rr    = 1'b1;
          w_win_idx   = rr_slot(r_rr_ptr, off);
        end
      end
    end
    w_win_oh   = w_win_valid ? (N_REQ'(1) << w_win_idx) : '0;
    w_win_addr = bus.addr[int'(w_win_idx)*AW +: AW];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt         <= '0;
      r_rom_address <= '0;
      r_rr_ptr      <= RR_FIRST;
    end else begin
      r_gnt <= w_win_oh;
      if (w_win_valid) r_rom_address <= w_win_addr;
      if (w_win_rr)    r_rr_ptr      <= rr_next(w_win_idx);
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < N_REQ; i++) r_wait[i] <= '0;
    end else begin
      for (int i = 1; i < N_REQ; i++) begin
        if (!bus.req[i] || w_win_oh[i]) r_wait[i] <= '0;
        else if (r_wait[i] != SAT)      r_wait[i] <= r_wait[i] + CW'(1);
      end
    end
  end

  // NOTE: the return pipeline array is reset on purpose: reads in flight at reset must never return.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROM_LAT; i++) r_pipe[i] <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_pipe[0] <= r_gnt;
      for (int i = 1; i < ROM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      r_rvalid <= r_pipe[ROM_LAT-1];
      if (|r_pipe[ROM_LAT-1]) r_rdata <= bus.rom_q;
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.rom_address = r_rom_address;
  assign bus.rvalid      = r_rvalid;
  assign bus.rdata       = r_rdata;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: stimulus pushes hand-derived grant/return
// expectations (with cycle stamps); a negedge monitor pops and compares them.
module tb_sprite_rom_arbiter;
  localparam int N_REQ = 4;
  localparam int AW    = 17;
  localparam int DW    = 4;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 vga_clk = ~vga_clk;

  sprite_rom_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

  sprite_rom_arbiter #(
    .N_REQ(N_REQ), .AW(AW), .DW(DW), .ROM_LAT(1), .STARVE_MAX(15)
  ) dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // One-cycle synchronous ROM whose contents are the low address nibble.
  always @(posedge vga_clk) bus.rom_q <= bus.rom_address[DW-1:0];

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0]      cyc;
    logic [N_REQ-1:0] oh;
    logic [AW-1:0]    val;
  } exp_t;

  exp_t gnt_q[$];
  exp_t ret_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t m_g, m_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every visible grant or return must match the head of its queue.
  always @(negedge vga_clk) begin
    if (reset_n) begin
      if (bus.gnt !== '0) begin
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 64'({16'(cyc), bus.gnt, bus.rom_address}), 64'(0));
        end else begin
          m_g = gnt_q.pop_front();
          check("gnt", 64'({16'(cyc), bus.gnt, bus.rom_address}), 64'(m_g));
        end
      end
      if (bus.rvalid !== '0) begin
        if (ret_q.size() == 0) begin
          check("rvalid_unexpected", 64'({16'(cyc), bus.rvalid, AW'(bus.rdata)}), 64'(0));
        end else begin
          m_r = ret_q.pop_front();
          check("rvalid", 64'({16'(cyc), bus.rvalid, AW'(bus.rdata)}), 64'(m_r));
        end
      end
    end
  end

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic set_in(input logic [N_REQ-1:0] r, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    bus.req  = r;
    bus.addr = {a3, a2, a1, a0};
  endtask

  // Request driven now: grant expected next cycle, return three cycles from now.
  task automatic exp_read(input int port, input logic [AW-1:0] a, input bit g, input bit r);
    exp_t e;
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[port] = 1'b1;
    if (g) begin
      e.cyc = 16'(cyc + 1); e.oh = oh; e.val = a;
      gnt_q.push_back(e);
    end
    if (r) begin
      e.cyc = 16'(cyc + 3); e.oh = oh; e.val = AW'(a[DW-1:0]);
      ret_q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 8 && (gnt_q.size() != 0 || ret_q.size() != 0); i++) tick();
    check(name, 64'(gnt_q.size() + ret_q.size()), 64'(0));
    gnt_q.delete();
    ret_q.delete();
    repeat (2) tick();
  endtask

  task automatic check_outs_zero(input string name);
    check(name, 64'({bus.gnt, bus.rvalid, bus.rom_address, bus.rdata}), 64'(0));
  endtask

  logic [AW-1:0] a[N_REQ];
  int port;

  initial begin
    a[0] = 17'h00A05; a[1] = 17'h1F0F1; a[2] = 17'h00022; a[3] = 17'h10033;
    set_in('0, '0, '0, '0, '0);
    repeat (2) @(posedge vga_clk);
    #1 check_outs_zero("por_outputs");
    reset_n = 1'b1;
    tick();

    // Reset mid-stream: only grants/returns completed before reset are expected.
    for (int k = 0; k < 6; k++) begin
      set_in(4'b0001, 17'h00100 + AW'(k), '0, '0, '0);
      exp_read(0, 17'h00100 + AW'(k), k <= 4, k <= 2);
      tick();
    end
    reset_n = 1'b0;
    set_in('0, '0, '0, '0, '0);
    #1 check_outs_zero("reset_outputs_0");
    tick();
    check_outs_zero("reset_outputs_1");
    tick();
    reset_n = 1'b1;
    check("pre_reset_reads", 64'(gnt_q.size() + ret_q.size()), 64'(0));
    repeat (3) tick();
    set_in(4'b0001, 17'h0ABCD, '0, '0, '0);
    exp_read(0, 17'h0ABCD, 1, 1);
    tick();
    set_in('0, '0, '0, '0, '0);
    drain("drain_reset");

    // Round-robin among ports 1..3, pointer starts at 1.
    set_in(4'b1110, '0, 17'h00011, a[2], a[3]);
    for (int k = 0; k < 6; k++) begin
      port = 1 + (k % 3);
      exp_read(port, (port == 1) ? 17'h00011 : a[port], 1, 1);
      tick();
    end
    set_in('0, '0, '0, '0, '0);
    drain("drain_rr");

    // Single read on port 2; pointer moves to 3.
    set_in(4'b0100, '0, '0, 17'h00123, '0);
    exp_read(2, 17'h00123, 1, 1);
    tick();
    set_in('0, '0, '0, '0, '0);
    drain("drain_single");

    // Starvation: port 1 pre-empts port 0 once every 16 grants.
    set_in(4'b0011, a[0], a[1], '0, '0);
    for (int k = 0; k < 32; k++) begin
      port = ((k % 16) == 15) ? 1 : 0;
      exp_read(port, a[port], 1, 1);
      tick();
    end
    set_in('0, '0, '0, '0, '0);
    drain("drain_starve");

    // Saturated counter with req dropped: clears, port 1 not granted afterwards.
    for (int k = 0; k < 19; k++) begin
      set_in((k == 15) ? 4'b0001 : 4'b0011, a[0], a[1], '0, '0);
      exp_read(0, a[0], 1, 1);
      tick();
    end
    set_in('0, '0, '0, '0, '0);
    drain("drain_saturate");

    // Starvation grants left the pointer at 3.
    set_in(4'b1110, '0, a[1], a[2], a[3]);
    exp_read(3, a[3], 1, 1); tick();
    exp_read(1, a[1], 1, 1); tick();
    exp_read(2, a[2], 1, 1); tick();
    set_in('0, '0, '0, '0, '0);
    drain("drain_rr_after_starve");

    // Tie between port 0 and port 3: port 0 first, then port 3.
    set_in(4'b1001, a[0], '0, '0, a[3]);
    exp_read(0, a[0], 1, 1);
    tick();
    set_in(4'b1000, a[0], '0, '0, a[3]);
    exp_read(3, a[3], 1, 1);
    tick();
    set_in('0, '0, '0, '0, '0);
    drain("drain_tie");

    // Pointer wrapped back to 1 after the port-3 grant.
    set_in(4'b1110, '0, a[1], a[2], a[3]);
    exp_read(1, a[1], 1, 1); tick();
    exp_read(2, a[2], 1, 1); tick();
    exp_read(3, a[3], 1, 1); tick();
    set_in('0, '0, '0, '0, '0);
    drain("drain_rr_after_tie");

    // Port 0 streams addresses 0..9 back to back.
    for (int k = 0; k < 10; k++) begin
      set_in(4'b0001, AW'(k), '0, '0, '0);
      exp_read(0, AW'(k), 1, 1);
      tick();
    end
    set_in('0, '0, '0, '0, '0);
    drain("drain_stream");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
